// File: rtl/pathtracer_la_bridge.sv
// rtl/pathtracer_la_bridge.sv - LA command/result bridge between host LA bus and pathtracer core
module pathtracer_la_bridge #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 4,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [127:0]      la_data_in,
  input  logic [127:0]      la_oenb,
  output logic [127:0]      la_data_out,
  output logic [DATA_W-1:0] cmd_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_valid,
  output logic              res_ready,
  output logic              irq
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SW  = DATA_W + 3;              // payload + cmd toggle + ack toggle + clear
  localparam int TOG = DATA_W;
  localparam int ACK = DATA_W + 1;
  localparam int CLR = DATA_W + 2;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [SW-1:0]     samp_q, samp_d;
  logic [2:0]        hist_q, hist_d;
  logic [DATA_W-1:0] cmd_mem_q [DEPTH];
  logic [DATA_W-1:0] cmd_mem_d [DEPTH];
  logic [DATA_W-1:0] res_mem_q [DEPTH];
  logic [DATA_W-1:0] res_mem_d [DEPTH];
  logic [AW-1:0]     cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [AW-1:0]     res_wr_q, res_wr_d, res_rd_q, res_rd_d;
  logic [CW-1:0]     cmd_count_q, cmd_count_d, res_count_q, res_count_d;
  logic              cmd_ack_q, cmd_ack_d, ovf_q, ovf_d, unf_q, unf_d;

  logic clr_ev, cmd_ev, ack_ev, cmd_pop, cmd_push, res_push, res_pop;
  logic [DATA_W-1:0] res_head;
  logic unused_la;

  // Bits above the control field carry nothing for this block
  assign unused_la = ^{la_data_in[127:SW], la_oenb[127:SW]};

  // Event decode and handshakes; a clear cycle suppresses every other event and the core handshake
  always_comb begin
    clr_ev    = samp_q[CLR] & ~hist_q[2];
    cmd_ev    = (samp_q[TOG] ^ hist_q[0]) & ~clr_ev;
    ack_ev    = (samp_q[ACK] ^ hist_q[1]) & ~clr_ev;
    cmd_valid = (cmd_count_q != '0) & ~clr_ev;
    cmd_pop   = cmd_valid & cmd_ready;
    cmd_push  = cmd_ev & ((cmd_count_q != FULL) | cmd_pop);
    res_ready = ~wb_rst_i & (res_count_q < FULL) & ~clr_ev;
    res_push  = res_valid & res_ready;
    res_pop   = ack_ev & (res_count_q != '0);
  end

  // Next-state: input sampling with per-bit hold, both FIFOs, stickies and soft clear
  always_comb begin
    samp_d      = (la_data_in[SW-1:0] & ~la_oenb[SW-1:0]) | (samp_q & la_oenb[SW-1:0]);
    hist_d      = samp_q[CLR:TOG];
    cmd_mem_d   = cmd_mem_q;
    res_mem_d   = res_mem_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_rd_d    = cmd_rd_q;
    res_wr_d    = res_wr_q;
    res_rd_d    = res_rd_q;
    cmd_count_d = cmd_count_q;
    res_count_d = res_count_q;
    cmd_ack_d   = cmd_ack_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    if (clr_ev) begin
      cmd_wr_d    = '0;
      cmd_rd_d    = '0;
      res_wr_d    = '0;
      res_rd_d    = '0;
      cmd_count_d = '0;
      res_count_d = '0;
      cmd_ack_d   = 1'b0;
      ovf_d       = 1'b0;
      unf_d       = 1'b0;
    end else begin
      if (cmd_push) begin
        cmd_mem_d[cmd_wr_q] = samp_q[DATA_W-1:0];
        cmd_wr_d            = cmd_wr_q + AW'(1);
        cmd_ack_d           = ~cmd_ack_q;
      end else if (cmd_ev) begin
        ovf_d = 1'b1;
      end
      if (cmd_pop) cmd_rd_d = cmd_rd_q + AW'(1);
      cmd_count_d = cmd_count_q + CW'(cmd_push) - CW'(cmd_pop);
      if (res_push) begin
        res_mem_d[res_wr_q] = res_data;
        res_wr_d            = res_wr_q + AW'(1);
      end
      if (res_pop) res_rd_d = res_rd_q + AW'(1);
      if (ack_ev && res_count_q == '0) unf_d = 1'b1;
      res_count_d = res_count_q + CW'(res_push) - CW'(res_pop);
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      samp_q      <= '0;
      hist_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        cmd_mem_q[i] <= '0;
        res_mem_q[i] <= '0;
      end
      cmd_wr_q    <= '0;
      cmd_rd_q    <= '0;
      res_wr_q    <= '0;
      res_rd_q    <= '0;
      cmd_count_q <= '0;
      res_count_q <= '0;
      cmd_ack_q   <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      samp_q      <= samp_d;
      hist_q      <= hist_d;
      cmd_mem_q   <= cmd_mem_d;
      res_mem_q   <= res_mem_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_rd_q    <= cmd_rd_d;
      res_wr_q    <= res_wr_d;
      res_rd_q    <= res_rd_d;
      cmd_count_q <= cmd_count_d;
      res_count_q <= res_count_d;
      cmd_ack_q   <= cmd_ack_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  // Output map: FIFO heads (zero when empty), status bits and occupancy counts
  always_comb begin
    cmd_data = (cmd_count_q != '0) ? cmd_mem_q[cmd_rd_q] : '0;
    res_head = (res_count_q != '0) ? res_mem_q[res_rd_q] : '0;
    irq      = (res_count_q != '0);
    la_data_out                        = '0;
    la_data_out[DATA_W-1:0]            = res_head;
    la_data_out[DATA_W]                = irq;
    la_data_out[DATA_W+1]              = cmd_ack_q;
    la_data_out[DATA_W+2]              = ovf_q;
    la_data_out[DATA_W+3]              = unf_q;
    la_data_out[DATA_W+4 +: CW]        = cmd_count_q;
    la_data_out[DATA_W+4+CW +: CW]     = res_count_q;
  end

endmodule
